// File: rtl/bp_me_accel_scratchpad_resp.sv
// BedRock mem_fwd responder backed by a local scratchpad: uncached writes are
// stored and acked, uncached reads return data beats on mem_rev.
module bp_me_accel_scratchpad_resp #(
  parameter int unsigned paddr_width_p   = 40,
  parameter int unsigned fill_width_p    = 64,
  parameter int unsigned payload_width_p = 16,
  parameter int unsigned els_p           = 256,
  localparam int unsigned mem_fwd_header_width_lp = paddr_width_p + payload_width_p + 11,
  localparam int unsigned mem_rev_header_width_lp = mem_fwd_header_width_lp
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [mem_fwd_header_width_lp-1:0] mem_fwd_header_i,
  input  logic [fill_width_p-1:0]            mem_fwd_data_i,
  input  logic                               mem_fwd_v_i,
  output logic                               mem_fwd_ready_and_o,
  output logic [mem_rev_header_width_lp-1:0] mem_rev_header_o,
  output logic [fill_width_p-1:0]            mem_rev_data_o,
  output logic                               mem_rev_v_o,
  input  logic                               mem_rev_ready_and_i,
  output logic [31:0]                        wr_count_o,
  output logic                               error_o
);

  localparam int unsigned bytes_lp    = fill_width_p / 8;
  localparam int unsigned off_w_lp    = $clog2(bytes_lp);
  localparam int unsigned idx_w_lp    = $clog2(els_p);
  localparam int unsigned addr_lsb_lp = 8;
  localparam int unsigned size_lsb_lp = 8 + paddr_width_p;

  typedef enum logic [3:0] {
    e_mem_rd    = 4'd0,
    e_mem_wr    = 4'd1,
    e_mem_uc_rd = 4'd2,
    e_mem_uc_wr = 4'd3
  } msg_type_e;

  typedef enum logic [2:0] {
    e_ready, e_write, e_wr_resp, e_rd_issue, e_rd_send
  } state_e;

  function automatic logic [7:0] last_beat_f(input logic [2:0] size);
    int unsigned n;
    n = (32'd1 << size) / bytes_lp;
    if (n == 0) n = 1;
    return 8'(n - 1);
  endfunction

  // Sub-word accesses are naturally aligned to their own size within the beat.
  function automatic logic [bytes_lp-1:0] byte_sel_f(input logic [2:0] size,
                                                     input logic [off_w_lp-1:0] off);
    int unsigned nb, base;
    logic [bytes_lp-1:0] sel;
    nb   = 32'd1 << size;
    base = 32'(off) & ~(nb - 32'd1);
    for (int unsigned b = 0; b < bytes_lp; b++)
      sel[b] = (b >= base) && (b < base + nb);
    return sel;
  endfunction

  function automatic logic [fill_width_p-1:0] rd_fmt_f(input logic [fill_width_p-1:0] word,
                                                       input logic [2:0] size,
                                                       input logic [off_w_lp-1:0] off);
    int unsigned nb, base;
    logic [fill_width_p-1:0] out;
    nb = 32'd1 << size;
    if (nb > bytes_lp) nb = bytes_lp;
    base = 32'(off) & ~(nb - 32'd1);
    for (int unsigned b = 0; b < bytes_lp; b++)
      out[b*8 +: 8] = word[(base + (b % nb))*8 +: 8];
    return out;
  endfunction

  state_e                             r_state, w_state_n;
  logic [mem_fwd_header_width_lp-1:0] r_hdr;
  logic [7:0]                         r_beat_cnt, r_last, w_cnt;
  logic                               r_nowr, r_error;
  logic [31:0]                        r_wr_count;
  logic [fill_width_p-1:0]            r_rd_word;
  logic [fill_width_p-1:0]            r_mem [els_p];

  logic                w_we;
  logic [3:0]          w_in_type;
  logic [2:0]          w_in_size, w_size;
  logic [idx_w_lp-1:0] w_base, w_idx;
  logic [off_w_lp-1:0] w_off;
  logic [bytes_lp-1:0] w_bsel;

  assign w_in_type = mem_fwd_header_i[3:0];
  assign w_in_size = mem_fwd_header_i[size_lsb_lp +: 3];

  always_comb begin
    w_state_n           = r_state;
    mem_fwd_ready_and_o = 1'b0;
    mem_rev_v_o         = 1'b0;
    w_we                = 1'b0;
    w_cnt               = r_beat_cnt;
    w_base              = r_hdr[addr_lsb_lp + off_w_lp +: idx_w_lp];
    w_off               = r_hdr[addr_lsb_lp +: off_w_lp];
    w_size              = r_hdr[size_lsb_lp +: 3];
    case (r_state)
      e_ready: begin
        mem_fwd_ready_and_o = 1'b1;
        w_cnt  = '0;
        w_base = mem_fwd_header_i[addr_lsb_lp + off_w_lp +: idx_w_lp];
        w_off  = mem_fwd_header_i[addr_lsb_lp +: off_w_lp];
        w_size = w_in_size;
        if (mem_fwd_v_i) begin
          if (w_in_type == e_mem_uc_rd) w_state_n = e_rd_issue;
          else begin
            w_we      = (w_in_type == e_mem_uc_wr);
            w_state_n = (last_beat_f(w_in_size) == '0) ? e_wr_resp : e_write;
          end
        end
      end
      e_write: begin
        mem_fwd_ready_and_o = 1'b1;
        if (mem_fwd_v_i) begin
          w_we = ~r_nowr;
          if (r_beat_cnt == r_last) w_state_n = e_wr_resp;
        end
      end
      e_wr_resp: begin
        mem_rev_v_o = 1'b1;
        if (mem_rev_ready_and_i) w_state_n = e_ready;
      end
      e_rd_issue: w_state_n = e_rd_send;
      e_rd_send: begin
        mem_rev_v_o = 1'b1;
        if (mem_rev_ready_and_i) w_state_n = (r_beat_cnt == r_last) ? e_ready : e_rd_issue;
      end
      default: w_state_n = e_ready;
    endcase
    if (reset_i) begin
      mem_fwd_ready_and_o = 1'b0;
      mem_rev_v_o         = 1'b0;
      w_we                = 1'b0;
    end
  end

  assign w_idx  = w_base + idx_w_lp'(w_cnt);
  assign w_bsel = byte_sel_f(w_size, w_off);

  always_ff @(posedge clk_i) begin
    if (w_we)
      for (int unsigned b = 0; b < bytes_lp; b++)
        if (w_bsel[b]) r_mem[w_idx][b*8 +: 8] <= mem_fwd_data_i[b*8 +: 8];
    if (r_state == e_rd_issue) r_rd_word <= r_mem[w_idx];
  end

  // Outside reset, ready is high in READY/WRITE, so v alone implies a handshake there.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= e_ready;
      r_hdr      <= '0;
      r_beat_cnt <= '0;
      r_last     <= '0;
      r_nowr     <= 1'b0;
      r_wr_count <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      case (r_state)
        e_ready: if (mem_fwd_v_i) begin
          r_hdr      <= mem_fwd_header_i;
          r_last     <= last_beat_f(w_in_size);
          r_nowr     <= (w_in_type != e_mem_uc_wr);
          r_beat_cnt <= (w_in_type == e_mem_uc_rd) ? 8'd0 : 8'd1;
          if ((w_in_type != e_mem_uc_wr) && (w_in_type != e_mem_uc_rd)) r_error <= 1'b1;
        end
        e_write:   if (mem_fwd_v_i) r_beat_cnt <= r_beat_cnt + 8'd1;
        e_wr_resp: if (mem_rev_ready_and_i && (r_wr_count != '1)) r_wr_count <= r_wr_count + 32'd1;
        e_rd_send: if (mem_rev_ready_and_i) r_beat_cnt <= r_beat_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  assign mem_rev_header_o = r_hdr;
  assign mem_rev_data_o   = (r_state == e_rd_send)
                          ? rd_fmt_f(r_rd_word, r_hdr[size_lsb_lp +: 3], r_hdr[addr_lsb_lp +: off_w_lp])
                          : '0;
  assign wr_count_o       = r_wr_count;
  assign error_o          = r_error;

endmodule
